// File: rtl/march_addr_seq_pkg.sv
// march_addr_seq_pkg: shared constants and the state encoding for the march
// address sequencer and its counter.
package march_addr_seq_pkg;

    localparam int ADDR_WIDTH_DFLT = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/march_addr_cnt.sv
// march_addr_cnt: binary up/down address counter with load, enable and
// terminal compare against the range bounds.
module march_addr_cnt #(
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] ADDR_MIN   = '0,
    parameter logic [ADDR_WIDTH-1:0] ADDR_MAX   = '1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_val,
    input  logic                  en,
    input  logic                  dir_down,
    output logic [ADDR_WIDTH-1:0] cnt,
    output logic [ADDR_WIDTH-1:0] cnt_nxt,
    output logic                  at_max,
    output logic                  at_min
);

    // NOTE: cnt_nxt is given its hold value before any branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_nxt = cnt;
        if (load) begin
            cnt_nxt = load_val;
        end else if (en) begin
            cnt_nxt = dir_down ? cnt - 1'b1 : cnt + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= ADDR_MIN;
        end else begin
            cnt <= cnt_nxt;
        end
    end

    assign at_max = (cnt == ADDR_MAX);
    assign at_min = (cnt == ADDR_MIN);

endmodule

// File: rtl/march_addr_seq.sv
// march_addr_seq: registered address sequencer for one PMBIST march element.
// Define PMBIST_GRAY_ADDR_EN to present addr as the Gray code of the binary counter.
module march_addr_seq
    import march_addr_seq_pkg::*;
#(
    parameter int                    ADDR_WIDTH = ADDR_WIDTH_DFLT,
    parameter logic [ADDR_WIDTH-1:0] ADDR_MIN   = '0,
    parameter logic [ADDR_WIDTH-1:0] ADDR_MAX   = '1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  dir,
    input  logic                  step,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  busy,
    output logic                  lu_out,
    output logic                  ld_out,
    output logic                  done
);

    state_t                state, state_nxt;
    logic                  dir_q, dir_nxt;
    logic                  cnt_load, cnt_en, term;
    logic                  at_max, at_min;
    logic [ADDR_WIDTH-1:0] cnt, cnt_nxt, load_val;

    assign term     = (dir_q == DIR_DOWN) ? at_min : at_max;
    assign load_val = (dir == DIR_DOWN) ? ADDR_MAX : ADDR_MIN;

    always_comb begin
        state_nxt = state;
        dir_nxt   = dir_q;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_RUN;
                    dir_nxt   = dir;
                    cnt_load  = 1'b1;
                end
            end
            ST_RUN: begin
                // Stepping at the terminal address ends the element instead of moving the counter.
                if (step) begin
                    if (term) state_nxt = ST_DONE;
                    else      cnt_en    = 1'b1;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    march_addr_cnt #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ADDR_MIN   (ADDR_MIN),
        .ADDR_MAX   (ADDR_MAX)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (load_val),
        .en       (cnt_en),
        .dir_down (dir_q),
        .cnt      (cnt),
        .cnt_nxt  (cnt_nxt),
        .at_max   (at_max),
        .at_min   (at_min)
    );

    // Flags are decoded from next-state values so they line up with the registered address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            dir_q  <= DIR_UP;
            busy   <= 1'b0;
            lu_out <= 1'b0;
            ld_out <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            dir_q  <= dir_nxt;
            busy   <= (state_nxt == ST_RUN);
            lu_out <= (state_nxt == ST_RUN) && (dir_nxt == DIR_UP)   && (cnt_nxt == ADDR_MAX);
            ld_out <= (state_nxt == ST_RUN) && (dir_nxt == DIR_DOWN) && (cnt_nxt == ADDR_MIN);
            done   <= (state_nxt == ST_DONE);
        end
    end

`ifdef PMBIST_GRAY_ADDR_EN
    logic [ADDR_WIDTH-1:0] addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= ADDR_MIN ^ (ADDR_MIN >> 1);
        end else begin
            addr_q <= cnt_nxt ^ (cnt_nxt >> 1);
        end
    end

    assign addr = addr_q;
`else
    assign addr = cnt;
`endif

endmodule

// File: tb/tb_march_addr_seq.sv
// tb_march_addr_seq: three sequencer instances (full 3-bit range, range 2..5,
// single address 4) driven by shared directed and random stimulus against an index-based model.
module tb_march_addr_seq;

    localparam int W      = 3;
    localparam int NI     = 3;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic clk = 1'b0;
    logic rst, start, dir, step;

    logic [W-1:0] a0, a1, a2;
    logic b0, b1, b2, lu0, lu1, lu2, ld0, ld1, ld2, d0, d1, d2;

    int n_checks = 0;
    int n_pass   = 0;

    int lo [NI] = '{0, 2, 4};
    int hi [NI] = '{7, 5, 4};
    int m_mode [NI];
    int m_idx  [NI];
    int m_dir  [NI];
    int m_addr [NI];

    int done_seen0, lu_seen0, ld_seen0;

    always #5 clk = ~clk;

    march_addr_seq #(.ADDR_WIDTH(W), .ADDR_MIN(3'd0), .ADDR_MAX(3'd7)) u_full (
        .clk(clk), .rst(rst), .start(start), .dir(dir), .step(step),
        .addr(a0), .busy(b0), .lu_out(lu0), .ld_out(ld0), .done(d0));

    march_addr_seq #(.ADDR_WIDTH(W), .ADDR_MIN(3'd2), .ADDR_MAX(3'd5)) u_range (
        .clk(clk), .rst(rst), .start(start), .dir(dir), .step(step),
        .addr(a1), .busy(b1), .lu_out(lu1), .ld_out(ld1), .done(d1));

    march_addr_seq #(.ADDR_WIDTH(W), .ADDR_MIN(3'd4), .ADDR_MAX(3'd4)) u_single (
        .clk(clk), .rst(rst), .start(start), .dir(dir), .step(step),
        .addr(a2), .busy(b2), .lu_out(lu2), .ld_out(ld2), .done(d2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [W-1:0] enc(input int a);
        logic [W-1:0] v;
        v = a[W-1:0];
`ifdef PMBIST_GRAY_ADDR_EN
        return v ^ (v >> 1);
`else
        return v;
`endif
    endfunction

    function automatic logic [6:0] obs(input int k);
        case (k)
            0:       return {a0, b0, lu0, ld0, d0};
            1:       return {a1, b1, lu1, ld1, d1};
            default: return {a2, b2, lu2, ld2, d2};
        endcase
    endfunction

    // The model tracks an index into the element's address list; addr is derived arithmetically.
    function automatic logic [6:0] expect_out(input int k);
        logic bz, is_last;
        bz      = (m_mode[k] == M_RUN);
        is_last = (m_idx[k] == hi[k] - lo[k]);
        return {enc(m_addr[k]), bz, bz && m_dir[k] == 0 && is_last,
                bz && m_dir[k] == 1 && is_last, m_mode[k] == M_DONE};
    endfunction

    task automatic model_edge(input logic r, input logic s, input logic d, input logic st);
        for (int k = 0; k < NI; k++) begin
            if (r) begin
                m_mode[k] = M_IDLE;
                m_idx[k]  = 0;
                m_dir[k]  = 0;
                m_addr[k] = lo[k];
            end else if (m_mode[k] == M_RUN) begin
                if (st) begin
                    if (m_idx[k] == hi[k] - lo[k]) m_mode[k] = M_DONE;
                    else                           m_idx[k]++;
                end
            end else if (m_mode[k] == M_DONE) begin
                m_mode[k] = M_IDLE;
            end else if (s) begin
                m_mode[k] = M_RUN;
                m_dir[k]  = int'(d);
                m_idx[k]  = 0;
            end
            if (m_mode[k] == M_RUN)
                m_addr[k] = (m_dir[k] == 1) ? hi[k] - m_idx[k] : lo[k] + m_idx[k];
        end
    endtask

    task automatic cycle(input logic r, input logic s, input logic d, input logic st);
        rst = r; start = s; dir = d; step = st;
        @(posedge clk);
        model_edge(r, s, d, st);
        #1;
        for (int k = 0; k < NI; k++)
            check($sformatf("inst%0d {addr,busy,lu,ld,done}", k), 32'(obs(k)), 32'(expect_out(k)));
        if (b0 && d0) check("busy_and_done_together", 32'(1), 32'(0));
        done_seen0 += int'(d0);
        lu_seen0   += int'(lu0);
        ld_seen0   += int'(ld0);
    endtask

    task automatic clear_counts();
        done_seen0 = 0; lu_seen0 = 0; ld_seen0 = 0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dir = 1'b0; step = 1'b0;
        for (int k = 0; k < NI; k++) begin
            m_mode[k] = M_IDLE; m_idx[k] = 0; m_dir[k] = 0; m_addr[k] = lo[k];
        end
        clear_counts();
        #1;

        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        check("reset_state", 32'(obs(0)), 32'({enc(0), 4'b0000}));

        // Step in IDLE is ignored.
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        check("idle_step_addr", 32'(a0), 32'(enc(0)));

        // Up walk, start and step in the same cycle: start wins.
        clear_counts();
        cycle(0, 1, 0, 1);
        check("start_with_step", 32'({a0, b0}), 32'({enc(0), 1'b1}));
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1);
        check("up_done_now", 32'({b0, d0}), 32'(2'b01));
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        check("up_done_count", 32'(done_seen0), 32'(1));
        check("up_lu_cycles", 32'(lu_seen0), 32'(1));
        check("up_idle_addr_held", 32'({a0, b0}), 32'({enc(7), 1'b0}));

        // Down walk stepping on alternate cycles.
        clear_counts();
        cycle(0, 1, 1, 0);
        check("down_first_addr", 32'(a0), 32'(enc(7)));
        for (int i = 0; i < 16; i++) cycle(0, 0, 0, 1'(i % 2));
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        check("down_done_count", 32'(done_seen0), 32'(1));
        check("down_ld_cycles", 32'(ld_seen0), 32'(2));

        // start/dir pulsed mid-walk is ignored.
        cycle(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1);
        cycle(0, 1, 1, 0);
        check("mid_start_ignored", 32'({a0, b0}), 32'({enc(3), 1'b1}));
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);

        // Reset mid-walk at addr 4 aborts without done.
        cycle(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1);
        check("pre_reset_addr", 32'(a0), 32'(enc(4)));
        clear_counts();
        cycle(1, 0, 0, 1);
        check("abort_outputs", 32'(obs(0)), 32'({enc(0), 4'b0000}));
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1);
        check("abort_no_done", 32'(done_seen0), 32'(0));

        // Randomized traffic.
        for (int i = 0; i < 1500; i++)
            cycle(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 5) == 0),
                  1'($urandom), 1'($urandom_range(0, 1)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
